// File: rtl/pc_gen.sv
// Program-counter generator for the rysy fetch stage: sequential advance, redirect, flush window.
// Optional macro PC_MISALIGN_TRAP_EN rejects misaligned redirect targets and pulses misalign.
`ifndef REG_LEN
`define REG_LEN 32
`endif

module pc_gen #(
  parameter logic [`REG_LEN-1:0] RESET_VEC    = 32'h0000_0000,
  parameter int unsigned         PC_STEP      = 4,
  parameter int unsigned         FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                jump_en,
  input  logic [`REG_LEN-1:0] jump_addr,
  output logic [`REG_LEN-1:0] pc,
  output logic                flush,
  output logic                misalign
);

  localparam int unsigned PC_W  = `REG_LEN;
  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  pc_q, pc_d;

`ifdef PC_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      pc_q    <= RESET_VEC;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Next-state: redirect beats stall; redirects seen during a flush belong to squashed code
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
`ifdef PC_MISALIGN_TRAP_EN
    misalign_d = 1'b0;
`endif
    if ((state_q == ST_RUN) && jump_en) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (jump_addr[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end else begin
        pc_d    = jump_addr;
        state_d = ST_FLUSH;
        cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
      end
`else
      pc_d    = jump_addr & ~PC_W'(3);
      state_d = ST_FLUSH;
      cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
`endif
    end else if (!stall) begin
      pc_d = pc_q + PC_W'(PC_STEP);
      if (state_q == ST_FLUSH) begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end
  end

  assign pc    = pc_q;
  assign flush = (state_q == ST_FLUSH);

`ifdef PC_MISALIGN_TRAP_EN
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, reset corner case, randomized run vs. model.
`timescale 1ns/1ps

module tb_pc_gen;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam int FLUSH_N = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic [31:0] pc;
  logic        flush;
  logic        misalign;

  pc_gen dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .pc        (pc),
    .flush     (flush),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        jen;
    logic [31:0] addr;
    logic [31:0] exp_pc;
    logic        exp_flush;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: remaining flush cycles rather than a state machine
  logic [31:0] m_pc;
  int          m_left;
  logic        m_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_pc   = 32'h0;
    m_left = 0;
    m_mis  = 1'b0;
  endfunction

  function automatic void model_step(input logic s, input logic j, input logic [31:0] a);
    m_mis = 1'b0;
    if (m_left == 0 && j) begin
      if (TRAP && a[1:0] != 2'b00) begin
        m_mis = 1'b1;
      end else begin
        m_pc   = a & 32'hFFFF_FFFC;
        m_left = FLUSH_N;
      end
    end else if (!s) begin
      m_pc = m_pc + 32'd4;
      if (m_left > 0) m_left--;
    end
  endfunction

  // Drive one cycle of inputs, let the edge pass, sample 1ns later
  task automatic step(input logic s, input logic j, input logic [31:0] a);
    stall = s; jump_en = j; jump_addr = a;
    @(posedge clk);
    #1;
    model_step(s, j, a);
  endtask

  function automatic void add(input logic s, input logic j, input logic [31:0] a,
                              input logic [31:0] p, input logic f, input logic m);
    vec_t v;
    v.stall = s; v.jen = j; v.addr = a; v.exp_pc = p; v.exp_flush = f; v.exp_mis = m;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    check("reset_pc", pc, 32'h0);
    check("reset_flush", {31'b0, flush}, 32'h0);
    check("reset_mis", {31'b0, misalign}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Reset asserted mid-flush clears pc and flush without a clock edge
    step(1'b0, 1'b1, 32'h100);
    check("pre_rst_flush", {31'b0, flush}, 32'h1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_flush", {31'b0, flush}, 32'h0);
    @(posedge clk); #1;
    check("rst_hold_pc", pc, 32'h0);
    rst = 1'b0;
    model_reset();

    add(0, 0, 32'h0,         32'h4,         0, 0);
    add(0, 0, 32'h0,         32'h8,         0, 0);
    add(0, 0, 32'h0,         32'hC,         0, 0);
    add(0, 0, 32'h0,         32'h10,        0, 0);
    add(0, 1, 32'h100,       32'h100,       1, 0);
    add(0, 1, 32'h200,       32'h104,       1, 0);
    add(0, 0, 32'h0,         32'h108,       0, 0);
    add(0, 0, 32'h0,         32'h10C,       0, 0);
    add(1, 1, 32'h40,        32'h40,        1, 0);
    add(1, 0, 32'h0,         32'h40,        1, 0);
    add(1, 0, 32'h0,         32'h40,        1, 0);
    add(1, 0, 32'h0,         32'h40,        1, 0);
    add(0, 0, 32'h0,         32'h44,        1, 0);
    add(0, 0, 32'h0,         32'h48,        0, 0);
    add(0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0);
    add(0, 0, 32'h0,         32'h0,         1, 0);
    add(0, 0, 32'h0,         32'h4,         0, 0);
    if (TRAP) begin
      add(0, 1, 32'h102, 32'h4,   0, 1);
      add(0, 0, 32'h0,   32'h8,   0, 0);
      add(0, 0, 32'h0,   32'hC,   0, 0);
    end else begin
      add(0, 1, 32'h102, 32'h100, 1, 0);
      add(0, 0, 32'h0,   32'h104, 1, 0);
      add(0, 0, 32'h0,   32'h108, 0, 0);
    end

    foreach (vecs[i]) begin
      step(vecs[i].stall, vecs[i].jen, vecs[i].addr);
      check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_flush", i), {31'b0, flush}, {31'b0, vecs[i].exp_flush});
      check($sformatf("vec%0d_mis", i), {31'b0, misalign}, {31'b0, vecs[i].exp_mis});
    end

    for (int c = 0; c < 500; c++) begin
      logic        s, j;
      logic [31:0] a;
      s = ($urandom_range(3) == 0);
      j = ($urandom_range(3) == 0);
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      step(s, j, a);
      check($sformatf("rnd%0d_pc", c), pc, m_pc);
      check($sformatf("rnd%0d_flush", c), {31'b0, flush}, {31'b0, (m_left > 0)});
      check($sformatf("rnd%0d_mis", c), {31'b0, misalign}, {31'b0, m_mis});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
